alu_mc: RTL

- Parametrised, registered successor to the single-cycle CPU's combinational ALU, for the multi-cycle CPU datapath.
- Adds signed compare, logical/arithmetic right shift and NOR as 1-cycle ops.
- Adds iterative unsigned multiply and divide with a start/busy/done handshake.
- Sits between the register file / immediate extender and the writeback mux; the control unit stalls on busy.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mc_iter.sv | 75 +++++++
 rtl/alu_mc.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM encoding for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SGTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1011;
    localparam logic [3:0] ALU_MULU = 4'b1100;
    localparam logic [3:0] ALU_DIVU = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide datapath, one step per cycle.
module alu_mc_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             opIsDiv,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] nextHi,
    output logic [WIDTH-1:0] nextLo,
    output logic             last
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic [WIDTH-1:0] operand;
    logic             isDiv;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Remainder stays below the divisor, so diff's top bit is a clean borrow flag.
    always_comb begin
        sum     = {1'b0, accHi} + {1'b0, operand};
        shifted = {accHi, accLo[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        nextHi  = accHi;
        nextLo  = accLo;
        if (isDiv) begin
            if (!diff[WIDTH]) begin
                nextHi = diff[WIDTH-1:0];
                nextLo = {accLo[WIDTH-2:0], 1'b1};
            end else begin
                nextHi = shifted[WIDTH-1:0];
                nextLo = {accLo[WIDTH-2:0], 1'b0};
            end
        end else if (accLo[0]) begin
            {nextHi, nextLo} = {sum, accLo[WIDTH-1:1]};
        end else begin
            {nextHi, nextLo} = {1'b0, accHi, accLo[WIDTH-1:1]};
        end
    end

    assign last = (count == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            isDiv <= 1'b0;
        end else if (load) begin
            count <= CW'(WIDTH);
            isDiv <= opIsDiv;
        end else if (step) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            accHi   <= '0;
            accLo   <= a;
            operand <= b;
        end else if (step) begin
            accHi <= nextHi;
            accLo <= nextLo;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative mulu/divu.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_ctr,
    input  logic             alu_src_a,
    input  logic             alu_src_b,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    input  logic [WIDTH-1:0] im_extend,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_zero
);

    state_t                  state;
    state_t                  nextState;
    logic [WIDTH-1:0]        opA;
    logic [WIDTH-1:0]        opB;
    logic signed [WIDTH-1:0] sA;
    logic signed [WIDTH-1:0] sB;
    logic [SHW-1:0]          shiftAmt;
    logic                    accept;
    logic                    iterLoad;
    logic                    iterLast;
    logic [WIDTH-1:0]        iterHi;
    logic [WIDTH-1:0]        iterLo;
    logic [WIDTH-1:0]        quickLo;
    logic [WIDTH-1:0]        quickHi;
    logic                    quickOvf;
    logic                    quickDivZero;

    function automatic logic addOverflow(input logic signed [WIDTH-1:0] x,
                                         input logic signed [WIDTH-1:0] y,
                                         input logic signed [WIDTH-1:0] s);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic subOverflow(input logic signed [WIDTH-1:0] x,
                                         input logic signed [WIDTH-1:0] y,
                                         input logic signed [WIDTH-1:0] d);
        return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
    endfunction

    assign opA      = alu_src_a ? {{(WIDTH-SHW){1'b0}}, shamt} : read_data1;
    assign opB      = alu_src_b ? im_extend : read_data2;
    assign sA       = opA;
    assign sB       = opB;
    assign shiftAmt = opA[SHW-1:0];
    assign accept   = start && (state != CALC);
    // Divide by zero short-circuits to the single-cycle path.
    assign iterLoad = accept && ((alu_ctr == ALU_MULU) ||
                                 (alu_ctr == ALU_DIVU && opB != '0));
    assign busy     = (state == CALC);
    assign done     = (state == DONE);

    alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .reset   (reset),
        .load    (iterLoad),
        .step    (state == CALC),
        .opIsDiv (alu_ctr == ALU_DIVU),
        .a       (opA),
        .b       (opB),
        .nextHi  (iterHi),
        .nextLo  (iterLo),
        .last    (iterLast)
    );

    always_comb begin
        quickLo      = '0;
        quickHi      = '0;
        quickOvf     = 1'b0;
        quickDivZero = 1'b0;
        case (alu_ctr)
            ALU_ADD: begin
                quickLo  = opA + opB;
                quickOvf = addOverflow(sA, sB, quickLo);
            end
            ALU_SUB: begin
                quickLo  = opA - opB;
                quickOvf = subOverflow(sA, sB, quickLo);
            end
            ALU_AND:  quickLo = opA & opB;
            ALU_OR:   quickLo = opA | opB;
            ALU_XOR:  quickLo = opA ^ opB;
            ALU_NOR:  quickLo = ~(opA | opB);
            ALU_SLL:  quickLo = opB << shiftAmt;
            ALU_SRL:  quickLo = opB >> shiftAmt;
            ALU_SRA:  quickLo = sB >>> shiftAmt;
            ALU_SLTU: quickLo = {{(WIDTH-1){1'b0}}, opA < opB};
            ALU_SGTU: quickLo = {{(WIDTH-1){1'b0}}, opA > opB};
            ALU_SLT:  quickLo = {{(WIDTH-1){1'b0}}, sA < sB};
            ALU_DIVU: begin
                quickLo      = '1;
                quickHi      = opA;
                quickDivZero = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE: begin
                if (accept) nextState = iterLoad ? CALC : DONE;
                else        nextState = IDLE;
            end
            CALC:    if (iterLast) nextState = DONE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            result_lo <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            state <= nextState;
            if (accept && !iterLoad) begin
                result_lo <= quickLo;
                result_hi <= quickHi;
                zero      <= (quickLo == '0);
                overflow  <= quickOvf;
                div_zero  <= quickDivZero;
            end else if (accept) begin
                zero     <= 1'b0;
                overflow <= 1'b0;
                div_zero <= 1'b0;
            end else if (state == CALC && iterLast) begin
                result_lo <= iterLo;
                result_hi <= iterHi;
                zero      <= (iterLo == '0);
            end
        end
    end

endmodule
